// File: rtl/seq_pkg.sv
// Shared constants for the microcode sequencer: default geometry, microcode entry layout,
// flag indices and the datapath control-bit map used by the fixed fetch words.
package seq_pkg;

  localparam int DEF_OPCODE_W  = 4;
  localparam int DEF_FLAG_W    = 4;
  localparam int DEF_CTRL_W    = 17;
  localparam int DEF_MAX_STEPS = 8;

  localparam int FLAG_CARRY  = 0;
  localparam int FLAG_ZERO   = 1;
  localparam int FLAG_SIGN   = 2;
  localparam int FLAG_PARITY = 3;

  localparam int CB_MAR_IN   = 2;
  localparam int CB_PC_INC   = 3;
  localparam int CB_RAM_OUT  = 5;
  localparam int CB_PC_OUT   = 7;
  localparam int CB_INSTR_IN = 9;
  localparam int CB_HALT     = 16;

  localparam logic [DEF_CTRL_W-1:0] DEF_FETCH0 = 17'h00084;
  localparam logic [DEF_CTRL_W-1:0] DEF_FETCH1 = 17'h00228;

  // Entry layout, LSB first: ctrl, cond_idx, cond_inv, cond_en, eoi.
  function automatic int cond_idx_w(input int flag_w);
    return (flag_w > 1) ? $clog2(flag_w) : 1;
  endfunction

  function automatic int entry_w(input int ctrl_w, input int flag_w);
    return ctrl_w + cond_idx_w(flag_w) + 3;
  endfunction

  localparam int COND_IDX_W   = cond_idx_w(DEF_FLAG_W);
  localparam int ENTRY_W      = entry_w(DEF_CTRL_W, DEF_FLAG_W);
  localparam int CTRL_LSB     = 0;
  localparam int COND_IDX_LSB = DEF_CTRL_W;
  localparam int COND_INV_BIT = COND_IDX_LSB + COND_IDX_W;
  localparam int COND_EN_BIT  = COND_INV_BIT + 1;
  localparam int EOI_BIT      = COND_EN_BIT + 1;

  typedef struct packed {
    logic                  eoi;
    logic                  cond_en;
    logic                  cond_inv;
    logic [COND_IDX_W-1:0] cond_idx;
    logic [DEF_CTRL_W-1:0] ctrl;
  } entry_t;

endpackage

// File: rtl/microcode_sequencer_if.sv
// Bus bundle between the sequencer and its IR/flags/microcode-loader environment.
// With SEQ_SINGLE_STEP_EN defined it also carries step_mode/step_req.
interface microcode_sequencer_if
  import seq_pkg::*;
#(
  parameter int OPCODE_W  = DEF_OPCODE_W,
  parameter int FLAG_W    = DEF_FLAG_W,
  parameter int CTRL_W    = DEF_CTRL_W,
  parameter int MAX_STEPS = DEF_MAX_STEPS
);
  localparam int STEP_W = $clog2(MAX_STEPS);
  localparam int E_W    = entry_w(CTRL_W, FLAG_W);

  logic [OPCODE_W-1:0]        opcode;
  logic [FLAG_W-1:0]          flags;
  logic                       resume;
  logic                       ucode_we;
  logic [OPCODE_W+STEP_W-1:0] ucode_addr;
  logic [E_W-1:0]             ucode_wdata;
  logic [CTRL_W-1:0]          ctrl;
  logic                       halted;
  logic [STEP_W-1:0]          step_out;
  logic                       step_ovf;
`ifdef SEQ_SINGLE_STEP_EN
  logic                       step_mode;
  logic                       step_req;

  modport master (
    output opcode, flags, resume, ucode_we, ucode_addr, ucode_wdata, step_mode, step_req,
    input  ctrl, halted, step_out, step_ovf
  );
  modport slave (
    input  opcode, flags, resume, ucode_we, ucode_addr, ucode_wdata, step_mode, step_req,
    output ctrl, halted, step_out, step_ovf
  );
`else
  modport master (
    output opcode, flags, resume, ucode_we, ucode_addr, ucode_wdata,
    input  ctrl, halted, step_out, step_ovf
  );
  modport slave (
    input  opcode, flags, resume, ucode_we, ucode_addr, ucode_wdata,
    output ctrl, halted, step_out, step_ovf
  );
`endif
endinterface

// File: rtl/microcode_store.sv
// Writable microcode store: synchronous write, combinational read. A read of the entry being
// written on the same edge sees the old contents.
module microcode_store #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 22
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [1<<ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/microcode_sequencer.sv
// Microcode-driven control sequencer: two fixed fetch steps, then per-opcode entries with
// flag conditions, early end-of-instruction, sticky halt/resume and a step-overflow trap.
// Optional single-step gating is compiled in with SEQ_SINGLE_STEP_EN.
module microcode_sequencer
  import seq_pkg::*;
#(
  parameter int                OPCODE_W  = DEF_OPCODE_W,
  parameter int                FLAG_W    = DEF_FLAG_W,
  parameter int                CTRL_W    = DEF_CTRL_W,
  parameter int                MAX_STEPS = DEF_MAX_STEPS,
  parameter int                HALT_BIT  = CB_HALT,
  parameter logic [CTRL_W-1:0] FETCH0    = CTRL_W'(DEF_FETCH0),
  parameter logic [CTRL_W-1:0] FETCH1    = CTRL_W'(DEF_FETCH1)
) (
  input  logic                 clk,
  input  logic                 rst,
  microcode_sequencer_if.slave bus
);
  localparam int STEP_W  = $clog2(MAX_STEPS);
  localparam int IDX_W   = cond_idx_w(FLAG_W);
  localparam int E_W     = entry_w(CTRL_W, FLAG_W);
  localparam int IDX_LSB = CTRL_W;
  localparam int INV_BIT = CTRL_W + IDX_W;
  localparam int EN_BIT  = INV_BIT + 1;
  localparam int EOI_BIT_L = EN_BIT + 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              halted_q, halted_d;
  logic              step_ovf_q, step_ovf_d;

  logic [E_W-1:0]    entry;
  logic [CTRL_W-1:0] e_ctrl;
  logic [IDX_W-1:0]  e_idx;
  logic              e_inv, e_en, e_eoi;
  logic              cond_true;
  logic              step_go;

  microcode_store #(
    .ADDR_W(OPCODE_W + STEP_W),
    .DATA_W(E_W)
  ) u_store (
    .clk  (clk),
    .we   (bus.ucode_we & rst),
    .waddr(bus.ucode_addr),
    .wdata(bus.ucode_wdata),
    .raddr({bus.opcode, step_q}),
    .rdata(entry)
  );

  assign e_ctrl    = entry[CTRL_W-1:0];
  assign e_idx     = entry[IDX_LSB +: IDX_W];
  assign e_inv     = entry[INV_BIT];
  assign e_en      = entry[EN_BIT];
  assign e_eoi     = entry[EOI_BIT_L];
  assign cond_true = !e_en || (bus.flags[e_idx] ^ e_inv);

`ifdef SEQ_SINGLE_STEP_EN
  assign step_go = !bus.step_mode || bus.step_req;
`else
  assign step_go = 1'b1;
`endif

  always_comb begin
    ctrl_d     = ctrl_q;
    step_d     = step_q;
    halted_d   = halted_q;
    step_ovf_d = step_ovf_q;
    if (halted_q) begin
      if (bus.resume) begin
        halted_d = 1'b0;
        ctrl_d   = '0;
        step_d   = '0;
      end
    end else if (!step_ovf_q) begin
      if (!step_go) begin
        ctrl_d = '0;
      end else begin
        if (step_q == '0) begin
          ctrl_d = FETCH0;
          step_d = STEP_W'(1);
        end else if (step_q == STEP_W'(1)) begin
          ctrl_d = FETCH1;
          step_d = STEP_W'(2);
        end else if (!cond_true) begin
          ctrl_d = '0;
          step_d = '0;
        end else if (e_eoi) begin
          ctrl_d = e_ctrl;
          step_d = '0;
        end else if (step_q == LAST_STEP) begin
          // Ran off the end of the instruction: trap and freeze until reset.
          ctrl_d     = '0;
          step_d     = '0;
          step_ovf_d = 1'b1;
        end else begin
          ctrl_d = e_ctrl;
          step_d = step_q + 1'b1;
        end
        halted_d = ctrl_d[HALT_BIT];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q     <= '0;
      step_q     <= '0;
      halted_q   <= 1'b0;
      step_ovf_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      step_q     <= step_d;
      halted_q   <= halted_d;
      step_ovf_q <= step_ovf_d;
    end
  end

  assign bus.ctrl     = ctrl_q;
  assign bus.halted   = halted_q;
  assign bus.step_out = step_q;
  assign bus.step_ovf = step_ovf_q;
endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed, table-driven bench for microcode_sequencer; exercises the single-step gating
// additionally when SEQ_SINGLE_STEP_EN is defined.
module tb_microcode_sequencer;
  import seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  microcode_sequencer_if #(.OPCODE_W(4), .FLAG_W(4), .CTRL_W(17), .MAX_STEPS(8)) bus ();

  microcode_sequencer dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic        rst;
    logic [3:0]  op;
    logic [3:0]  flags;
    logic        resume;
    logic [16:0] ctrl;
    logic [2:0]  step;
    logic        halted;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input int idx, input logic [16:0] c,
                             input logic [2:0] s, input logic h, input logic o);
    check({tag, ".ctrl"}, idx, 32'(bus.ctrl), 32'(c));
    check({tag, ".step"}, idx, 32'(bus.step_out), 32'(s));
    check({tag, ".halted"}, idx, 32'(bus.halted), 32'(h));
    check({tag, ".ovf"}, idx, 32'(bus.step_ovf), 32'(o));
    $display("%s #%0d: op=%0d flags=%b ctrl=0x%05h step=%0d halted=%0b ovf=%0b",
             tag, idx, bus.opcode, bus.flags, bus.ctrl, bus.step_out, bus.halted, bus.step_ovf);
  endtask

  task automatic edge_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ucode_write(input logic [3:0] op, input logic [2:0] s, input logic [21:0] d);
    bus.ucode_we    = 1'b1;
    bus.ucode_addr  = {op, s};
    bus.ucode_wdata = d;
    edge_step();
    bus.ucode_we    = 1'b0;
  endtask

  task automatic add(input logic r, input logic [3:0] op, input logic [3:0] f, input logic res,
                     input logic [16:0] c, input logic [2:0] s, input logic h, input logic o);
    vecs.push_back({r, op, f, res, c, s, h, o});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    entry_t e;
    bus.opcode      = '0;
    bus.flags       = '0;
    bus.resume      = 1'b0;
    bus.ucode_we    = 1'b0;
    bus.ucode_addr  = '0;
    bus.ucode_wdata = '0;
`ifdef SEQ_SINGLE_STEP_EN
    bus.step_mode   = 1'b0;
    bus.step_req    = 1'b0;
`endif
    @(negedge clk);
    edge_step();
    edge_step();
    check_state("reset", 0, 17'h0, 3'd0, 1'b0, 1'b0);

    rst = 1'b1;
    ucode_write(4'd1, 3'd2, 22'h000180);
    ucode_write(4'd1, 3'd3, 22'h208020);
    e = '{eoi: 1'b1, cond_en: 1'b1, cond_inv: 1'b0, cond_idx: 2'(FLAG_ZERO), ctrl: 17'h00102};
    ucode_write(4'd9, 3'd2, e);
    ucode_write(4'd10, 3'd2, 22'h180041);
    ucode_write(4'd10, 3'd3, 22'h200011);
    ucode_write(4'd11, 3'd2, 22'h210000);
    ucode_write(4'd3, 3'd2, 22'h200111);
    for (int s = 2; s < 8; s++) begin
      ucode_write(4'd5, 3'(s), 22'(17'h00400 + s));
    end

    //  rst op     flags   res ctrl       step h  o
    add(0, 4'd1,  4'b0000, 0, 17'h00000, 3'd0, 0, 0);
    add(1, 4'd1,  4'b0000, 0, 17'h00084, 3'd1, 0, 0);
    add(1, 4'd1,  4'b0000, 0, 17'h00228, 3'd2, 0, 0);
    add(1, 4'd1,  4'b0000, 0, 17'h00180, 3'd3, 0, 0);
    add(1, 4'd1,  4'b0000, 0, 17'h08020, 3'd0, 0, 0);
    add(1, 4'd1,  4'b0000, 0, 17'h00084, 3'd1, 0, 0);
    add(1, 4'd9,  4'b0010, 0, 17'h00228, 3'd2, 0, 0);
    add(1, 4'd9,  4'b0010, 0, 17'h00102, 3'd0, 0, 0);
    add(1, 4'd9,  4'b0000, 0, 17'h00084, 3'd1, 0, 0);
    add(1, 4'd9,  4'b0000, 1, 17'h00228, 3'd2, 0, 0);
    add(1, 4'd9,  4'b0000, 0, 17'h00000, 3'd0, 0, 0);
    add(1, 4'd10, 4'b0000, 0, 17'h00084, 3'd1, 0, 0);
    add(1, 4'd10, 4'b0000, 0, 17'h00228, 3'd2, 0, 0);
    add(1, 4'd10, 4'b0000, 0, 17'h00041, 3'd3, 0, 0);
    add(1, 4'd10, 4'b0000, 0, 17'h00011, 3'd0, 0, 0);
    add(1, 4'd10, 4'b0001, 0, 17'h00084, 3'd1, 0, 0);
    add(1, 4'd10, 4'b0001, 0, 17'h00228, 3'd2, 0, 0);
    add(1, 4'd10, 4'b0001, 0, 17'h00000, 3'd0, 0, 0);
    add(1, 4'd5,  4'b0000, 0, 17'h00084, 3'd1, 0, 0);
    add(1, 4'd5,  4'b0000, 0, 17'h00228, 3'd2, 0, 0);
    add(1, 4'd5,  4'b0000, 0, 17'h00402, 3'd3, 0, 0);
    add(1, 4'd5,  4'b0000, 0, 17'h00403, 3'd4, 0, 0);
    add(1, 4'd5,  4'b0000, 0, 17'h00404, 3'd5, 0, 0);
    add(1, 4'd5,  4'b0000, 0, 17'h00405, 3'd6, 0, 0);
    add(1, 4'd5,  4'b0000, 0, 17'h00406, 3'd7, 0, 0);
    add(1, 4'd5,  4'b0000, 0, 17'h00000, 3'd0, 0, 1);
    add(1, 4'd1,  4'b0000, 0, 17'h00000, 3'd0, 0, 1);
    add(1, 4'd1,  4'b0000, 1, 17'h00000, 3'd0, 0, 1);
    add(0, 4'd1,  4'b0000, 0, 17'h00000, 3'd0, 0, 0);
    add(1, 4'd1,  4'b0000, 0, 17'h00084, 3'd1, 0, 0);

    foreach (vecs[i]) begin
      rst        = vecs[i].rst;
      bus.opcode = vecs[i].op;
      bus.flags  = vecs[i].flags;
      bus.resume = vecs[i].resume;
      edge_step();
      check_state("vec", i, vecs[i].ctrl, vecs[i].step, vecs[i].halted, vecs[i].ovf);
    end
    bus.resume = 1'b0;

    // Halt: ctrl and step freeze until a resume pulse, then fetch restarts.
    bus.opcode = 4'd11;
    edge_step();
    check_state("hlt", 0, 17'h00228, 3'd2, 1'b0, 1'b0);
    edge_step();
    check_state("hlt", 1, 17'h10000, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus.flags = 4'(i);
      edge_step();
      check_state("hlt_hold", i, 17'h10000, 3'd0, 1'b1, 1'b0);
    end
    bus.resume = 1'b1;
    edge_step();
    check_state("resume", 0, 17'h00000, 3'd0, 1'b0, 1'b0);
    bus.resume = 1'b0;
    bus.opcode = 4'd3;
    edge_step();
    check_state("resume", 1, 17'h00084, 3'd1, 1'b0, 1'b0);

    // Rewrite {op3, s2} on the very edge that reads it.
    edge_step();
    check_state("rw", 0, 17'h00228, 3'd2, 1'b0, 1'b0);
    ucode_write(4'd3, 3'd2, 22'h200222);
    check_state("rw", 1, 17'h00111, 3'd0, 1'b0, 1'b0);
    edge_step();
    check_state("rw", 2, 17'h00084, 3'd1, 1'b0, 1'b0);
    edge_step();
    check_state("rw", 3, 17'h00228, 3'd2, 1'b0, 1'b0);
    edge_step();
    check_state("rw", 4, 17'h00222, 3'd0, 1'b0, 1'b0);

`ifdef SEQ_SINGLE_STEP_EN
    bus.opcode    = 4'd1;
    bus.step_mode = 1'b1;
    for (int i = 0; i < 7; i++) begin
      logic [16:0] exp_c;
      logic [2:0]  exp_s;
      bus.step_req = (i % 2 == 1);
      edge_step();
      case (i)
        0: begin exp_c = 17'h00000; exp_s = 3'd0; end
        1: begin exp_c = 17'h00084; exp_s = 3'd1; end
        2: begin exp_c = 17'h00000; exp_s = 3'd1; end
        3: begin exp_c = 17'h00228; exp_s = 3'd2; end
        4: begin exp_c = 17'h00000; exp_s = 3'd2; end
        5: begin exp_c = 17'h00180; exp_s = 3'd3; end
        default: begin exp_c = 17'h00000; exp_s = 3'd3; end
      endcase
      check_state("sstep", i, exp_c, exp_s, 1'b0, 1'b0);
    end
    bus.step_mode = 1'b0;
    bus.step_req  = 1'b0;
    edge_step();
    check_state("sstep", 7, 17'h08020, 3'd0, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
